// File: rtl/simple_axi_pkg.sv
// Shared types for the simple_axi command sequencer: rw codes, FSM states, response status.
package simple_axi_pkg;

  localparam logic [1:0] RW_NOP   = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    CLEAR = 2'b11
  } seq_state_t;

  typedef enum logic [1:0] {
    RSP_OKAY    = 2'b00,
    RSP_ERROR   = 2'b01,
    RSP_INVALID = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_status_t;

  // An invalid command outranks a bus error when the master flags both.
  function automatic rsp_status_t done_status(input logic invalid, input logic error);
    if (invalid) return RSP_INVALID;
    if (error)   return RSP_ERROR;
    return RSP_OKAY;
  endfunction

endpackage

// File: rtl/simple_axi_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is presented combinationally on rdata_o.
module simple_axi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/simple_axi_cmd_sequencer.sv
// Queues host commands and runs the strobe/done/clear handshake with simple_axi_master.
// Optional watchdog in WAIT: define SIMPLE_AXI_SEQ_TIMEOUT_EN.
module simple_axi_cmd_sequencer
  import simple_axi_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int CMD_DEPTH   = 4,
  parameter int RSP_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [1:0]            s_cmd_rw,
  input  logic [2:0]            s_cmd_size,
  input  logic [31:0]           s_cmd_addr,
  input  logic [DATA_WIDTH-1:0] s_cmd_wdata,
  output logic                  m_rsp_valid,
  input  logic                  m_rsp_ready,
  output logic [DATA_WIDTH-1:0] m_rsp_rdata,
  output logic [1:0]            m_rsp_status,
  output logic [1:0]            o_rw,
  output logic [2:0]            o_size,
  output logic [31:0]           o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_wait,
  input  logic                  i_done,
  input  logic                  i_error,
  input  logic                  i_invalid,
  output logic                  o_clear,
  output logic                  o_busy
);

  localparam int CMD_W = 2 + 3 + 32 + DATA_WIDTH;
  localparam int RSP_W = DATA_WIDTH + 2;

  seq_state_t            state_q;
  logic [1:0]            cur_rw_q, o_rw_q;
  logic [2:0]            o_size_q;
  logic [31:0]           o_addr_q;
  logic [DATA_WIDTH-1:0] o_wdata_q;
  logic                  o_clear_q;

  logic             cmd_full, cmd_empty, cmd_pop;
  logic [CMD_W-1:0] cmd_rdata;
  logic             rsp_full, rsp_empty, rsp_push, done_ok, to_fire;
  logic [RSP_W-1:0] rsp_wdata, rsp_rdata;

  simple_axi_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (s_cmd_valid),
    .wdata_i ({s_cmd_rw, s_cmd_size, s_cmd_addr, s_cmd_wdata}),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_rdata),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  simple_axi_sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (rsp_push),
    .wdata_i (rsp_wdata),
    .pop_i   (m_rsp_ready),
    .rdata_o (rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  assign cmd_pop = (state_q == IDLE) && !cmd_empty && !i_wait;
  assign done_ok = (state_q == WAIT) && i_done && !rsp_full;

`ifdef SIMPLE_AXI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt_q;
  logic          to_hit;

  assign to_hit  = (to_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign to_fire = (state_q == WAIT) && !i_done && to_hit && !rsp_full;

  // Saturates at the limit so a full response FIFO just delays the timeout push.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != WAIT) to_cnt_q <= '0;
    else if (!to_hit)             to_cnt_q <= to_cnt_q + TW'(1);
  end
`else
  assign to_fire = 1'b0;
`endif

  assign rsp_push  = done_ok || to_fire;
  assign rsp_wdata = to_fire ? {{DATA_WIDTH{1'b0}}, RSP_TIMEOUT}
                             : {(cur_rw_q == RW_READ) ? i_rdata : {DATA_WIDTH{1'b0}},
                                done_status(i_invalid, i_error)};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cur_rw_q  <= RW_NOP;
      o_rw_q    <= RW_NOP;
      o_size_q  <= '0;
      o_addr_q  <= '0;
      o_wdata_q <= '0;
      o_clear_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (cmd_pop) begin
          {cur_rw_q, o_size_q, o_addr_q, o_wdata_q} <= cmd_rdata;
          o_rw_q  <= cmd_rdata[CMD_W-1 -: 2];
          state_q <= ISSUE;
        end
        ISSUE: begin
          o_rw_q  <= RW_NOP;
          state_q <= WAIT;
        end
        WAIT: if (rsp_push) begin
          o_clear_q <= 1'b1;
          state_q   <= CLEAR;
        end
        CLEAR: begin
          o_clear_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign s_cmd_ready  = !cmd_full;
  assign m_rsp_valid  = !rsp_empty;
  assign m_rsp_rdata  = rsp_rdata[RSP_W-1:2];
  assign m_rsp_status = rsp_rdata[1:0];
  assign o_rw         = o_rw_q;
  assign o_size       = o_size_q;
  assign o_addr       = o_addr_q;
  assign o_wdata      = o_wdata_q;
  assign o_clear      = o_clear_q;
  assign o_busy       = (state_q != IDLE) || !cmd_empty;

endmodule
